// File: rtl/xdma_irq_pkg.sv
// rtl/xdma_irq_pkg.sv - shared state encoding and limits for the XDMA user-interrupt controller
package xdma_irq_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ASSERT   = 2'd1,
        DEASSERT = 2'd2
    } irq_state_e;

    localparam int NUM_CH_MIN      = 1;
    localparam int NUM_CH_MAX      = 16;
    localparam int ACK_TIMEOUT_MIN = 2;
    localparam int ACK_TIMEOUT_MAX = 65535;
    localparam int SYNC_STAGES_MAX = 3;
    localparam int CNT_W           = 16;

endpackage

// File: rtl/xdma_irq_chan.sv
// rtl/xdma_irq_chan.sv - one user-interrupt channel: edge detect, pending latch, ack/timeout FSM
module xdma_irq_chan
    import xdma_irq_pkg::*;
#(
    parameter bit LEGACY      = 1'b0,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_req,
    input  logic i_ack,
    output logic o_usr_irq_req,
    output logic o_req_ack,
    output logic o_timeout,
    output logic o_busy
);

    irq_state_e        state;
    logic [CNT_W-1:0]  cnt;
    logic              req_q;
    logic              armed;
    logic              pending;
    logic              rise;
    logic              expired;

    // armed stays low for the first cycle after reset so a level held through reset is not an edge
    assign rise    = armed & i_req & ~req_q;
    assign expired = (cnt == CNT_W'(ACK_TIMEOUT - 1));
    assign o_busy  = (state != IDLE) | pending;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= IDLE;
            cnt           <= '0;
            req_q         <= 1'b0;
            armed         <= 1'b0;
            pending       <= 1'b0;
            o_usr_irq_req <= 1'b0;
            o_req_ack     <= 1'b0;
            o_timeout     <= 1'b0;
        end else begin
            req_q     <= i_req;
            armed     <= 1'b1;
            o_req_ack <= 1'b0;
            o_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise || pending) begin
                        state         <= ASSERT;
                        o_usr_irq_req <= 1'b1;
                        pending       <= 1'b0;
                        cnt           <= '0;
                    end
                end
                ASSERT: begin
                    if (rise) pending <= 1'b1;
                    if (cnt != '1) cnt <= cnt + 1'b1;
                    // ack takes priority over an expiry landing in the same cycle
                    if (i_ack) begin
                        o_usr_irq_req <= 1'b0;
                        o_req_ack     <= 1'b1;
                        state         <= LEGACY ? DEASSERT : IDLE;
                        cnt           <= '0;
                    end else if (expired) begin
                        o_usr_irq_req <= 1'b0;
                        o_timeout     <= 1'b1;
                        pending       <= 1'b1;
                        state         <= IDLE;
                        cnt           <= '0;
                    end
                end
                DEASSERT: begin
                    if (rise) pending <= 1'b1;
                    if (cnt != '1) cnt <= cnt + 1'b1;
                    if (i_ack || expired) begin
                        o_timeout <= ~i_ack;
                        state     <= IDLE;
                        cnt       <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/xdma_irq_ctrl_mc.sv
// rtl/xdma_irq_ctrl_mc.sv - multi-channel XDMA user-interrupt controller top
module xdma_irq_ctrl_mc
    import xdma_irq_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter bit LEGACY      = 1'b0,
    parameter int ACK_TIMEOUT = 1024,
    parameter int SYNC_STAGES = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NUM_CH-1:0] i_req,
    output logic [NUM_CH-1:0] o_req_ack,
    output logic [NUM_CH-1:0] o_usr_irq_req,
    input  logic [NUM_CH-1:0] i_usr_irq_ack,
    output logic [NUM_CH-1:0] o_timeout,
    output logic              o_busy
);

    localparam int SYNC_N = (SYNC_STAGES > SYNC_STAGES_MAX) ? SYNC_STAGES_MAX : SYNC_STAGES;
    localparam int TO_N   = (ACK_TIMEOUT < ACK_TIMEOUT_MIN) ? ACK_TIMEOUT_MIN :
                            (ACK_TIMEOUT > ACK_TIMEOUT_MAX) ? ACK_TIMEOUT_MAX : ACK_TIMEOUT;

    logic [NUM_CH-1:0] ack_s;
    logic [NUM_CH-1:0] busy;

    generate
        if (SYNC_N == 0) begin : g_nosync
            assign ack_s = i_usr_irq_ack;
        end else begin : g_sync
            logic [NUM_CH-1:0] sync_q [SYNC_N];
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    for (int s = 0; s < SYNC_N; s++) sync_q[s] <= '0;
                end else begin
                    sync_q[0] <= i_usr_irq_ack;
                    for (int s = 1; s < SYNC_N; s++) sync_q[s] <= sync_q[s-1];
                end
            end
            assign ack_s = sync_q[SYNC_N-1];
        end

        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            xdma_irq_chan #(
                .LEGACY      (LEGACY),
                .ACK_TIMEOUT (TO_N)
            ) u_chan (
                .i_clk         (i_clk),
                .i_rst         (i_rst),
                .i_req         (i_req[c]),
                .i_ack         (ack_s[c]),
                .o_usr_irq_req (o_usr_irq_req[c]),
                .o_req_ack     (o_req_ack[c]),
                .o_timeout     (o_timeout[c]),
                .o_busy        (busy[c])
            );
        end
    endgenerate

    assign o_busy = |busy;

endmodule

// File: tb/tb_xdma_irq_ctrl_mc.sv
// tb/tb_xdma_irq_ctrl_mc.sv - randomized scoreboard bench for two controller configurations
module tb_xdma_irq_ctrl_mc;

    localparam int TO       = 8;
    localparam int M_IDLE   = 0;
    localparam int M_WAIT1  = 1;
    localparam int M_WAIT2  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req = '0;
    logic [1:0] ack = '0;

    logic [1:0] a_irq, a_rack, a_to;
    logic       a_busy;
    logic [1:0] b_irq, b_rack, b_to;
    logic       b_busy;

    typedef struct packed {
        logic [1:0] irq;
        logic [1:0] rack;
        logic [1:0] to;
        logic       busy;
    } obs_t;

    obs_t exp_q [$];
    int   tests = 0;
    int   failed = 0;
    int   cyc = 0;

    int   st    [2][2];
    int   start [2][2];
    bit   pend  [2][2];
    bit   prevr [2][2];
    bit   line  [2][2][3];
    bit   armed [2];

    always #5 clk = ~clk;

    xdma_irq_ctrl_mc #(.NUM_CH(2), .LEGACY(1'b0), .ACK_TIMEOUT(TO), .SYNC_STAGES(0)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_req(req), .o_req_ack(a_rack),
        .o_usr_irq_req(a_irq), .i_usr_irq_ack(ack), .o_timeout(a_to), .o_busy(a_busy));

    xdma_irq_ctrl_mc #(.NUM_CH(2), .LEGACY(1'b1), .ACK_TIMEOUT(TO), .SYNC_STAGES(2)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_req(req), .o_req_ack(b_rack),
        .o_usr_irq_req(b_irq), .i_usr_irq_ack(ack), .o_timeout(b_to), .o_busy(b_busy));

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            armed[d] = 1'b0;
            for (int c = 0; c < 2; c++) begin
                st[d][c] = M_IDLE; start[d][c] = 0; pend[d][c] = 1'b0; prevr[d][c] = 1'b0;
                for (int k = 0; k < 3; k++) line[d][c][k] = 1'b0;
            end
        end
    endtask

    // One clock edge of the reference: dut index 0 is MSI single-ack, index 1 legacy with 2 sync stages.
    task automatic model_step(output obs_t ea, output obs_t eb);
        obs_t e [2];
        for (int d = 0; d < 2; d++) begin
            int syn = (d == 1) ? 2 : 0;
            e[d] = '0;
            for (int c = 0; c < 2; c++) begin
                bit a, rise, late;
                a = (syn == 0) ? ack[c] : line[d][c][syn-1];
                for (int k = 2; k > 0; k--) line[d][c][k] = line[d][c][k-1];
                line[d][c][0] = ack[c];
                rise = armed[d] && req[c] && !prevr[d][c];
                prevr[d][c] = req[c];
                late = (st[d][c] != M_IDLE) && (cyc - start[d][c] == TO - 1);
                if (st[d][c] == M_IDLE) begin
                    if (rise || pend[d][c]) begin
                        st[d][c] = M_WAIT1; start[d][c] = cyc + 1; pend[d][c] = 1'b0;
                    end
                end else if (st[d][c] == M_WAIT1) begin
                    if (rise) pend[d][c] = 1'b1;
                    if (a) begin
                        e[d].rack[c] = 1'b1;
                        st[d][c] = (d == 1) ? M_WAIT2 : M_IDLE;
                        start[d][c] = cyc + 1;
                    end else if (late) begin
                        e[d].to[c] = 1'b1; st[d][c] = M_IDLE; pend[d][c] = 1'b1;
                    end
                end else begin
                    if (rise) pend[d][c] = 1'b1;
                    if (a) st[d][c] = M_IDLE;
                    else if (late) begin
                        e[d].to[c] = 1'b1; st[d][c] = M_IDLE;
                    end
                end
                e[d].irq[c] = (st[d][c] == M_WAIT1);
                if (st[d][c] != M_IDLE || pend[d][c]) e[d].busy = 1'b1;
            end
            armed[d] = 1'b1;
        end
        cyc++;
        ea = e[0];
        eb = e[1];
    endtask

    task automatic issue();
        obs_t ea, eb;
        model_step(ea, eb);
        exp_q.push_back(ea);
        exp_q.push_back(eb);
    endtask

    task automatic drive_random();
        req[0] = req[0] ^ ($urandom_range(0, 3) == 0);
        req[1] = req[1] ^ ($urandom_range(0, 3) == 0);
        ack[0] = ($urandom_range(0, 5) == 0);
        ack[1] = ($urandom_range(0, 5) == 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " a_irq"},  a_irq,  2'b00);
        chk({tag, " a_rack"}, a_rack, 2'b00);
        chk({tag, " a_to"},   a_to,   2'b00);
        chk({tag, " a_busy"}, {1'b0, a_busy}, 2'b00);
        chk({tag, " b_irq"},  b_irq,  2'b00);
        chk({tag, " b_rack"}, b_rack, 2'b00);
        chk({tag, " b_to"},   b_to,   2'b00);
        chk({tag, " b_busy"}, {1'b0, b_busy}, 2'b00);
    endtask

    always @(posedge clk) begin : monitor
        obs_t ea, eb;
        #1;
        if (exp_q.size() >= 2) begin
            ea = exp_q.pop_front();
            eb = exp_q.pop_front();
            chk("a_irq",  a_irq,  ea.irq);
            chk("a_rack", a_rack, ea.rack);
            chk("a_to",   a_to,   ea.to);
            chk("a_busy", {1'b0, a_busy}, {1'b0, ea.busy});
            chk("b_irq",  b_irq,  eb.irq);
            chk("b_rack", b_rack, eb.rack);
            chk("b_to",   b_to,   eb.to);
            chk("b_busy", {1'b0, b_busy}, {1'b0, eb.busy});
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (i > 0) @(negedge clk);
            drive_random();
            issue();
        end

        // asynchronous reset in the middle of a cycle, with requests held high across it
        @(posedge clk);
        #3;
        req = 2'b11;
        rst = 1'b1;
        #1;
        chk_all_zero("async_reset");
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ack = 2'b00;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            issue();
        end
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            drive_random();
            issue();
        end

        repeat (2) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            tests++;
            failed++;
            $display("FAIL drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/xdma_irq_ctrl_mc.md
XDMA_IRQ_CTRL_MC -- requirements
Module: xdma_irq_ctrl_mc

Interface
REQ-001 Parameter NUM_CH, default 2: number of independent XDMA user-interrupt channels; legal range 1..16.
REQ-002 Parameter LEGACY, default 0: 1 means each channel waits for a second XDMA ack after deasserting its request; 0 means MSI/MSI-X single-ack mode.
REQ-003 Parameter ACK_TIMEOUT, default 1024: cycles a channel waits for an ack before abandoning it; legal range 2..65535.
REQ-004 Parameter SYNC_STAGES, default 0: flip-flop stages applied to i_usr_irq_ack before use; legal range 0..3.
REQ-005 i_clk  in  1  block clock; all logic is in this domain.
REQ-006 i_rst  in  1  reset, asynchronous, active-high.
REQ-007 i_req  in  NUM_CH  per-channel interrupt request; only a rising edge is an event.
REQ-008 o_req_ack  out  NUM_CH  one-cycle pulse per channel when its interrupt is accepted by XDMA.
REQ-009 o_usr_irq_req  out  NUM_CH  to XDMA usr_irq_req.
REQ-010 i_usr_irq_ack  in  NUM_CH  from XDMA usr_irq_ack.
REQ-011 o_timeout  out  NUM_CH  one-cycle pulse per channel when an ack wait expires.
REQ-012 o_busy  out  1  OR over all channels of (state != IDLE or pending set).

Function
REQ-013 Each channel SHALL register i_req and detect a rising edge as (i_req & ~i_req_q).
REQ-014 Each channel SHALL run the FSM IDLE -> ASSERT -> (DEASSERT only if LEGACY=1) -> IDLE.
REQ-015 IDLE: on an edge or on pending=1, the channel SHALL enter ASSERT on the next cycle; o_usr_irq_req goes high one cycle after the edge cycle; pending clears.
REQ-016 ASSERT: o_usr_irq_req SHALL be held high, and a 16-bit wait counter SHALL increment every cycle.
REQ-017 ASSERT, on synced ack=1: o_usr_irq_req drops the next cycle, o_req_ack pulses the same next cycle, and the FSM goes to DEASSERT (LEGACY=1) or IDLE (LEGACY=0).
REQ-018 ASSERT, when the counter equals ACK_TIMEOUT-1 with no ack: o_usr_irq_req drops, o_timeout pulses for one cycle, the FSM goes to IDLE, and pending is set so the interrupt is retried.
REQ-019 Ack and timeout in the same cycle: the ack SHALL win and no o_timeout pulse is generated.
REQ-020 DEASSERT: o_usr_irq_req stays low; the second ack or timeout expiry returns the FSM to IDLE; timeout here pulses o_timeout but sets no pending.
REQ-021 An edge arriving while a channel is not in IDLE SHALL set pending; multiple edges coalesce into one pending bit.
REQ-022 An edge in the same cycle as an ack SHALL set pending, and that channel re-asserts after returning to IDLE.
REQ-023 A channel SHALL hold o_usr_irq_req low for at least one cycle between consecutive assertions.
REQ-024 An ack arriving while a channel is in IDLE SHALL be ignored with no pulse and no state change.
REQ-025 Channels SHALL be fully independent; simultaneous activity on all NUM_CH channels is legal.
REQ-026 SYNC_STAGES adds exactly SYNC_STAGES cycles of ack-to-response latency; 0 means a direct combinational sample of i_usr_irq_ack into the FSM.
REQ-027 The wait counter SHALL clear on every state entry and SHALL never wrap.

Reset
REQ-028 Asserting i_rst SHALL immediately force all outputs to 0, all FSMs to IDLE, and all pending bits, counters, sync flops and i_req_q to 0.
REQ-029 Reset asserted mid-ASSERT SHALL drop o_usr_irq_req asynchronously, with no o_req_ack or o_timeout pulse.
REQ-030 After release, an i_req already high SHALL NOT produce an event until it falls and rises again.

Structure
REQ-031 A shared package xdma_irq_pkg SHALL hold the FSM state enum (IDLE, ASSERT, DEASSERT), the parameter range limits and the counter width constant (16).
REQ-032 Per-channel logic SHALL be the sub-module xdma_irq_chan, instantiated NUM_CH times by a generate loop; the top level only instantiates channels, runs the ack synchronisers and forms o_busy.

Verification
REQ-033 NUM_CH=2, LEGACY=0, SYNC_STAGES=0: i_req[0] rises at cycle 10 and ack[0] pulses at cycle 15 -> o_usr_irq_req[0] is high for cycles 11-15 and o_req_ack[0] pulses at cycle 16; channel 1 stays at 0.
REQ-034 LEGACY=1: first ack at cycle 15 and second ack at cycle 20 -> req low from cycle 16, FSM back in IDLE at cycle 21; a new edge at cycle 18 asserts req at cycle 22.
REQ-035 ACK_TIMEOUT=8 with no ack: edge at cycle 0 -> o_timeout pulses at cycle 9, req is low for one cycle, then req re-asserts (retry via pending).
REQ-036 Three i_req[1] edges during ASSERT -> exactly one further assertion after the ack; a total of 2 o_req_ack pulses.
REQ-037 Ack on cycle ACK_TIMEOUT-1 -> o_req_ack pulses, o_timeout stays 0; then i_rst mid-ASSERT -> all outputs 0 within the same cycle, and i_req held high through the reset release produces no assertion.
REQ-038 Both channels receive edges in the same cycle with SYNC_STAGES=2 -> both reqs assert together, and each o_req_ack pulse lags its ack by 3 cycles.
